// File: rtl/alu_req_scheduler.sv
// Two-requester round-robin front end for the shared 4-bit ALU; one op in flight, optional ALU_OPCNT_EN op counter.
// Latency: response valid SETTLE_CYC cycles after accept; illegal opcodes respond in the cycle right after accept.
// Backpressure: rsp_* held stable while rsp_ready=0; no request is accepted until the response handshake completes.
module alu_req_scheduler #(
    parameter int unsigned SETTLE_CYC = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [7:0]       req_opcode,
    input  logic [7:0]       req_a,
    input  logic [7:0]       req_b,
    input  logic [1:0]       req_cin,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [7:0]       rsp_y,
    output logic [3:0]       rsp_cout,
    output logic             rsp_err,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic             alu_cin,
    output logic [3:0]       alu_opcode,
    input  logic [3:0]       alu_y,
    input  logic [7:0]       alu_y8,
    input  logic [3:0]       alu_cout,
`ifdef ALU_OPCNT_EN
    output logic [CNT_W-1:0] op_count,
`endif
    output logic             busy
);

    if (SETTLE_CYC < 1 || SETTLE_CYC > 15 || CNT_W < 1) begin : g_param_chk
        $error("alu_req_scheduler: SETTLE_CYC must be 1..15 and CNT_W >= 1");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYC);
    localparam logic [3:0] OP_LAST     = 4'd10;
    localparam logic [3:0] OP_MUL      = 4'd9;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       rr_q, rr_d;
    logic [3:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, alu_op_q, alu_op_d;
    logic       alu_cin_q, alu_cin_d;
    logic       rsp_id_q, rsp_id_d, rsp_err_q, rsp_err_d;
    logic [7:0] rsp_y_q, rsp_y_d;
    logic [3:0] rsp_cout_q, rsp_cout_d;

    logic [1:0] grant;
    logic       acc, acc_id, acc_cin;
    logic [3:0] acc_op, acc_a, acc_b;

    // Fixed priority when only one requester asks; rr_q breaks ties.
    always_comb begin
        grant = req_valid;
        if (req_valid == 2'b11) begin
            grant = rr_q ? 2'b10 : 2'b01;
        end
        req_ready = (state_q == IDLE) ? grant : 2'b00;
    end

    assign acc     = |req_ready;
    assign acc_id  = req_ready[1];
    assign acc_op  = acc_id ? req_opcode[7:4] : req_opcode[3:0];
    assign acc_a   = acc_id ? req_a[7:4]      : req_a[3:0];
    assign acc_b   = acc_id ? req_b[7:4]      : req_b[3:0];
    assign acc_cin = acc_id ? req_cin[1]      : req_cin[0];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rr_d       = rr_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        alu_cin_d  = alu_cin_q;
        rsp_id_d   = rsp_id_q;
        rsp_err_d  = rsp_err_q;
        rsp_y_d    = rsp_y_q;
        rsp_cout_d = rsp_cout_q;
        case (state_q)
            IDLE: begin
                if (acc) begin
                    rsp_id_d = acc_id;
                    rr_d     = ~acc_id;
                    if (acc_op <= OP_LAST) begin
                        alu_a_d   = acc_a;
                        alu_b_d   = acc_b;
                        alu_op_d  = acc_op;
                        alu_cin_d = acc_cin;
                        cnt_d     = SETTLE_INIT;
                        state_d   = SETTLE;
                    end else begin
                        // ALU is never driven with an illegal opcode; previous operands stay put.
                        rsp_err_d  = 1'b1;
                        rsp_y_d    = 8'd0;
                        rsp_cout_d = 4'd0;
                        state_d    = RESP;
                    end
                end
            end
            SETTLE: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    rsp_y_d    = (alu_op_q == OP_MUL) ? alu_y8 : {4'd0, alu_y};
                    rsp_cout_d = alu_cout;
                    rsp_err_d  = 1'b0;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            rr_q       <= 1'b0;
            alu_a_q    <= 4'd0;
            alu_b_q    <= 4'd0;
            alu_op_q   <= 4'd0;
            alu_cin_q  <= 1'b0;
            rsp_id_q   <= 1'b0;
            rsp_err_q  <= 1'b0;
            rsp_y_q    <= 8'd0;
            rsp_cout_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rr_q       <= rr_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            alu_cin_q  <= alu_cin_d;
            rsp_id_q   <= rsp_id_d;
            rsp_err_q  <= rsp_err_d;
            rsp_y_q    <= rsp_y_d;
            rsp_cout_q <= rsp_cout_d;
        end
    end

    assign rsp_valid  = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign rsp_id     = rsp_id_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_y      = rsp_y_q;
    assign rsp_cout   = rsp_cout_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_cin    = alu_cin_q;
    assign alu_opcode = alu_op_q;

`ifdef ALU_OPCNT_EN
    logic [CNT_W-1:0] op_count_q, op_count_d;

    // Counts successful ALU operations only; error responses are excluded.
    always_comb begin
        op_count_d = op_count_q;
        if (rsp_valid && rsp_ready && !rsp_err_q && (op_count_q != {CNT_W{1'b1}})) begin
            op_count_d = op_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_q <= '0;
        end else begin
            op_count_q <= op_count_d;
        end
    end

    assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Bench for alu_req_scheduler: directed scenarios plus randomized traffic against a transaction-level model.
// A behavioural ALU answers the DUT's registered operand outputs; expected responses come from the request fields.
module tb_alu_req_scheduler;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [1:0] req_valid = 2'b00, req_cin = 2'b00;
    logic [7:0] req_opcode = 8'd0, req_a = 8'd0, req_b = 8'd0;
    logic       rsp_ready = 1'b0;
    logic [1:0] req_ready;
    logic       rsp_valid, rsp_id, rsp_err, busy, alu_cin;
    logic [7:0] rsp_y, alu_y8;
    logic [3:0] rsp_cout, alu_a, alu_b, alu_opcode, alu_y, alu_cout;

    logic [1:0] req_valid4 = 2'b00;
    logic       rsp_ready4 = 1'b0;
    logic [1:0] req_ready4;
    logic       rsp_valid4, rsp_id4, rsp_err4, busy4, alu_cin4;
    logic [7:0] rsp_y4, alu_y84;
    logic [3:0] rsp_cout4, alu_a4, alu_b4, alu_opcode4, alu_y4, alu_cout4;
`ifdef ALU_OPCNT_EN
    logic [15:0] op_count, op_count4;
`endif

    int errors = 0;
    int checks = 0;

    // Behavioural ALU: returns {cout, y_8bit, y}. Y_8bit always carries the product.
    function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [3:0] a,
                                           input logic [3:0] b, input logic cin);
        logic [4:0] s;
        logic [7:0] p;
        logic [3:0] y, co;
        p  = 8'(a) * 8'(b);
        y  = 4'd0;
        co = 4'd0;
        case (op)
            4'd0:  begin s = 5'(a) + 5'(b) + 5'(cin); y = s[3:0]; co = {3'b0, s[4]}; end
            4'd1:  begin s = 5'(a) - 5'(b) - 5'(cin); y = s[3:0]; co = {3'b0, s[4]}; end
            4'd2:  y = a & b;
            4'd3:  y = a | b;
            4'd4:  y = a ^ b;
            4'd5:  y = ~a;
            4'd6:  begin y = {a[2:0], cin}; co = {3'b0, a[3]}; end
            4'd7:  begin y = {cin, a[3:1]}; co = {3'b0, a[0]}; end
            4'd8:  begin s = 5'(a) + 5'd1; y = s[3:0]; co = {3'b0, s[4]}; end
            4'd9:  begin y = p[3:0]; co = p[7:4]; end
            4'd10: begin s = 5'(a) - 5'd1; y = s[3:0]; co = {3'b0, s[4]}; end
            default: y = 4'hF;
        endcase
        return {co, p, y};
    endfunction

    // Expected response {err, cout, y} for one request.
    function automatic logic [12:0] exp_rsp(input logic [3:0] op, input logic [3:0] a,
                                            input logic [3:0] b, input logic cin);
        logic [15:0] r;
        if (op > 4'd10) return {1'b1, 12'd0};
        r = alu_fn(op, a, b, cin);
        return {1'b0, r[15:12], (op == 4'd9) ? r[11:4] : {4'd0, r[3:0]}};
    endfunction

    assign {alu_cout, alu_y8, alu_y}    = alu_fn(alu_opcode, alu_a, alu_b, alu_cin);
    assign {alu_cout4, alu_y84, alu_y4} = alu_fn(alu_opcode4, alu_a4, alu_b4, alu_cin4);

    alu_req_scheduler #(.SETTLE_CYC(1), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y),
        .rsp_cout(rsp_cout), .rsp_err(rsp_err), .alu_a(alu_a), .alu_b(alu_b),
        .alu_cin(alu_cin), .alu_opcode(alu_opcode), .alu_y(alu_y), .alu_y8(alu_y8),
        .alu_cout(alu_cout),
`ifdef ALU_OPCNT_EN
        .op_count(op_count),
`endif
        .busy(busy)
    );

    alu_req_scheduler #(.SETTLE_CYC(4), .CNT_W(16)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid4), .req_ready(req_ready4),
        .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4), .rsp_id(rsp_id4), .rsp_y(rsp_y4),
        .rsp_cout(rsp_cout4), .rsp_err(rsp_err4), .alu_a(alu_a4), .alu_b(alu_b4),
        .alu_cin(alu_cin4), .alu_opcode(alu_opcode4), .alu_y(alu_y4), .alu_y8(alu_y84),
        .alu_cout(alu_cout4),
`ifdef ALU_OPCNT_EN
        .op_count(op_count4),
`endif
        .busy(busy4)
    );

    task automatic do_reset();
        req_valid = 2'b00; req_valid4 = 2'b00; rsp_ready = 1'b0; rsp_ready4 = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Drives one request until accepted, waits for the response, stalls, then handshakes.
    task automatic run_txn(input logic [1:0] v, input logic [7:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic [1:0] cin, input int stall,
                           output int gid, output int lat, output logic [7:0] y,
                           output logic [3:0] co, output logic er, output logic id,
                           output bit ok, output bit stable);
        req_valid = v; req_opcode = op; req_a = a; req_b = b; req_cin = cin;
        rsp_ready = 1'b0;
        gid = -1; lat = -1; ok = 0; stable = 1;
        y = 8'd0; co = 4'd0; er = 1'b0; id = 1'b0;
        for (int k = 0; k < 40 && gid < 0; k++) begin
            #1;
            if (req_ready != 2'b00) gid = int'(req_ready[1]);
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
        if (gid >= 0) begin
            lat = 0;
            while (!rsp_valid && lat < 40) begin
                @(posedge clk); #1;
                lat++;
            end
            if (rsp_valid) begin
                ok = 1;
                y = rsp_y; co = rsp_cout; er = rsp_err; id = rsp_id;
                req_valid = 2'b11;
                for (int s = 0; s < stall; s++) begin
                    @(posedge clk); #1;
                    if (!rsp_valid || rsp_y !== y || rsp_cout !== co || rsp_err !== er ||
                        rsp_id !== id || req_ready !== 2'b00 || busy !== 1'b1) stable = 0;
                end
                req_valid = 2'b00;
                rsp_ready = 1'b1;
                @(posedge clk); #1;
                rsp_ready = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 2'b00; req_valid4 = 2'b00;
        @(posedge clk); #1;
        checks++;
        if ({rsp_valid, busy, req_ready, rsp_id, rsp_err, rsp_y, rsp_cout,
             alu_a, alu_b, alu_cin, alu_opcode} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got y=%h cout=%h busy=%b vld=%b alu_op=%h want all 0",
                     rsp_y, rsp_cout, busy, rsp_valid, alu_opcode);
        end
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        int gid, lat; logic [7:0] y; logic [3:0] co; logic er, id; bit ok, st;
        run_txn(2'b01, 8'h00, 8'h0E, 8'h05, 2'b00, 0, gid, lat, y, co, er, id, ok, st);
        checks++; if (!ok)       begin errors++; $display("FAIL add_timeout got ok=0 want 1"); end
        checks++; if (lat != 1)  begin errors++; $display("FAIL add_latency got %0d want 1", lat); end
        checks++; if (id !== 1'b0 || gid != 0) begin errors++; $display("FAIL add_id got %0d/%0d want 0", id, gid); end
        checks++; if (y !== 8'h03) begin errors++; $display("FAIL add_y got %h want 03", y); end
        checks++; if (co !== 4'h1) begin errors++; $display("FAIL add_cout got %h want 1", co); end
        run_txn(2'b10, 8'h90, 8'hC0, 8'h30, 2'b00, 0, gid, lat, y, co, er, id, ok, st);
        checks++; if (y !== 8'h24) begin errors++; $display("FAIL mul_y got %h want 24", y); end
        checks++; if (er !== 1'b0 || id !== 1'b1) begin errors++; $display("FAIL mul_err_id got %b/%b want 0/1", er, id); end
    endtask

    task automatic test_illegal();
        int gid, lat; logic [7:0] y; logic [3:0] co; logic er, id; bit ok, st;
        run_txn(2'b01, 8'h0F, 8'h07, 8'h07, 2'b01, 0, gid, lat, y, co, er, id, ok, st);
        checks++; if (lat != 0) begin errors++; $display("FAIL ill_latency got %0d want 0 (valid right after accept)", lat); end
        checks++; if ({er, co, y} !== {1'b1, 12'd0}) begin errors++; $display("FAIL ill_rsp got err=%b y=%h cout=%h want 1/00/0", er, y, co); end
        checks++; if (alu_opcode !== 4'h9 || alu_a !== 4'hC) begin errors++; $display("FAIL ill_alu_hold got op=%h a=%h want 9/c", alu_opcode, alu_a); end
    endtask

    task automatic test_arbitration();
        int gid, lat; logic [7:0] y; logic [3:0] co; logic er, id; bit ok, st;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            run_txn(2'b11, 8'h42, 8'hBC, 8'h6B, 2'b00, 0, gid, lat, y, co, er, id, ok, st);
            checks++;
            if (gid != (i % 2)) begin errors++; $display("FAIL rr_grant[%0d] got %0d want %0d", i, gid, i % 2); end
            checks++;
            if (y !== ((i % 2 == 0) ? 8'h08 : 8'h0D)) begin
                errors++; $display("FAIL rr_y[%0d] got %h want %h", i, y, (i % 2 == 0) ? 8'h08 : 8'h0D);
            end
        end
    endtask

    task automatic test_backpressure();
        int gid, lat; logic [7:0] y; logic [3:0] co; logic er, id; bit ok, st;
        run_txn(2'b10, 8'h10, 8'h90, 8'h30, 2'b10, 5, gid, lat, y, co, er, id, ok, st);
        checks++; if (!st) begin errors++; $display("FAIL bp_stable got unstable rsp/ready/busy want stable"); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_release got busy=%b want 0", busy); end
        checks++; if (y !== 8'h05) begin errors++; $display("FAIL bp_y got %h want 05", y); end
    endtask

    task automatic test_random();
        int gid, lat, exp_gid, stall; logic [7:0] y; logic [3:0] co; logic er, id; bit ok, st;
        logic [1:0] v; logic [7:0] op, a, b; logic [1:0] cin;
        logic rr; logic [3:0] last_op, lop, la, lb; logic [12:0] e;
        int legal_cnt;
        do_reset();
        rr = 1'b0; last_op = 4'd0; legal_cnt = 0;
        for (int t = 0; t < 30; t++) begin
            v = 2'($urandom_range(1, 3));
            op = 8'($urandom); a = 8'($urandom); b = 8'($urandom); cin = 2'($urandom);
            stall = $urandom_range(0, 3);
            exp_gid = (v == 2'b11) ? int'(rr) : ((v == 2'b10) ? 1 : 0);
            lop = (exp_gid == 1) ? op[7:4] : op[3:0];
            la  = (exp_gid == 1) ? a[7:4]  : a[3:0];
            lb  = (exp_gid == 1) ? b[7:4]  : b[3:0];
            e = exp_rsp(lop, la, lb, cin[exp_gid]);
            run_txn(v, op, a, b, cin, stall, gid, lat, y, co, er, id, ok, st);
            rr = (exp_gid == 0);
            if (!e[12]) begin last_op = lop; legal_cnt++; end
            checks++;
            if (gid != exp_gid || id !== 1'(exp_gid)) begin
                errors++; $display("FAIL rnd_grant[%0d] got %0d/%0d want %0d", t, gid, id, exp_gid);
            end
            checks++;
            if (lat != (e[12] ? 0 : 1)) begin
                errors++; $display("FAIL rnd_latency[%0d] got %0d want %0d", t, lat, e[12] ? 0 : 1);
            end
            checks++;
            if ({er, co, y} !== e) begin
                errors++; $display("FAIL rnd_rsp[%0d] op=%h got err=%b cout=%h y=%h want err=%b cout=%h y=%h",
                                   t, lop, er, co, y, e[12], e[11:8], e[7:0]);
            end
            checks++;
            if (!st || busy !== 1'b0) begin errors++; $display("FAIL rnd_stall[%0d] got stable=%0d busy=%b want 1/0", t, st, busy); end
            checks++;
            if (alu_opcode !== last_op) begin errors++; $display("FAIL rnd_alu_op[%0d] got %h want %h", t, alu_opcode, last_op); end
        end
`ifdef ALU_OPCNT_EN
        checks++;
        if (op_count !== 16'(legal_cnt)) begin errors++; $display("FAIL rnd_op_count got %0d want %0d", op_count, legal_cnt); end
`endif
    endtask

    task automatic test_settle4_reset();
        int lat; bit seen;
        do_reset();
        req_opcode = 8'h00; req_a = 8'h03; req_b = 8'h04; req_cin = 2'b00;
        req_valid4 = 2'b01;
        #1;
        checks++; if (req_ready4 !== 2'b01) begin errors++; $display("FAIL s4_ready got %b want 01", req_ready4); end
        @(posedge clk); #1;
        req_valid4 = 2'b00;
        lat = 0;
        while (!rsp_valid4 && lat < 40) begin @(posedge clk); #1; lat++; end
        checks++; if (lat != 4) begin errors++; $display("FAIL s4_latency got %0d want 4", lat); end
        checks++; if (rsp_y4 !== 8'h07) begin errors++; $display("FAIL s4_y got %h want 07", rsp_y4); end
        rsp_ready4 = 1'b1;
        @(posedge clk); #1;
        rsp_ready4 = 1'b0;
        req_valid4 = 2'b01;
        @(posedge clk); #1;
        req_valid4 = 2'b00;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy4, rsp_valid4, req_ready4, rsp_id4, rsp_err4, rsp_cout4, rsp_y4,
             alu_a4, alu_b4, alu_cin4, alu_opcode4} !== '0) begin
            errors++; $display("FAIL s4_abort_outputs got busy=%b y=%h a=%h want all 0", busy4, rsp_y4, alu_a4);
        end
`ifdef ALU_OPCNT_EN
        checks++; if (op_count4 !== 16'd0) begin errors++; $display("FAIL s4_op_count got %0d want 0", op_count4); end
`endif
        @(posedge clk); #1 rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (rsp_valid4) seen = 1;
        end
        checks++; if (seen) begin errors++; $display("FAIL s4_no_response got rsp_valid=1 want 0"); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_illegal();
        test_arbitration();
        test_backpressure();
        test_random();
        test_settle4_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
